// File: rtl/commutator_p.sv
// Parametrised delay-switch-delay commutator: transposes LANES lanes by LANES groups
// of STAGE beats between FFT butterfly stages, with stall, bypass and frame-done support.

module commutator_p_dly #(
    parameter int NB    = 32,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [NB-1:0] d,
    output logic [NB-1:0] q
);

    logic [NB-1:0] sr_q [DEPTH];
    logic [NB-1:0] sr_d [DEPTH];

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        sr_d = sr_q;
        if (en) begin
            sr_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: delay storage is cleared explicitly, so these stay flops rather than a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

module commutator_p #(
    parameter int NB    = 32,
    parameter int LANES = 4,
    parameter int STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                bypass,
    input  logic                in_valid,
    input  logic [NB*LANES-1:0] in_data,
    output logic                out_valid,
    output logic [NB*LANES-1:0] out_data,
    output logic                done
);

    localparam int FILL = (LANES - 1) * STAGE;
    localparam int RW   = $clog2(LANES);
    localparam int SW   = (STAGE > 1) ? $clog2(STAGE) : 1;
    localparam int FW   = $clog2(FILL + 1);

    // Beat counter split into (switch position, beat within position) to avoid a divider.
    logic [SW-1:0] sub_q, sub_d, sub_cur;
    logic [RW-1:0] r_q, r_d, r_cur;
    logic [FW-1:0] fill_q, fill_d, fill_cur;
    logic          done_seen_q, done_seen_d, done_seen_cur;
    logic          primed;

    always_comb begin
        sub_cur       = start ? '0 : sub_q;
        r_cur         = start ? '0 : r_q;
        fill_cur      = start ? '0 : fill_q;
        done_seen_cur = start ? 1'b0 : done_seen_q;
        primed        = (fill_cur == FW'(FILL));

        out_valid   = ~reset & in_valid & (bypass | primed);
        done        = ~bypass & out_valid & ~done_seen_cur;

        sub_d       = sub_cur;
        r_d         = r_cur;
        fill_d      = fill_cur;
        done_seen_d = done_seen_cur | done;

        if (bypass) begin
            sub_d  = '0;
            r_d    = '0;
            fill_d = '0;
        end else if (in_valid) begin
            if (sub_cur == SW'(STAGE - 1)) begin
                sub_d = '0;
                r_d   = r_cur + 1'b1;
            end else begin
                sub_d = sub_cur + 1'b1;
            end
            if (!primed) begin
                fill_d = fill_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q       <= '0;
            r_q         <= '0;
            fill_q      <= '0;
            done_seen_q <= 1'b0;
        end else begin
            sub_q       <= sub_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            done_seen_q <= done_seen_d;
        end
    end

    logic [NB-1:0]       dl [LANES];
    logic [NB-1:0]       sw [LANES];
    logic [NB*LANES-1:0] xpose_data;

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            sw[j] = dl[r_cur - RW'(j)];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == 0) begin : g_in_direct
            assign dl[k] = in_data[NB*k +: NB];
        end else begin : g_in_dly
            commutator_p_dly #(.NB(NB), .DEPTH(k * STAGE)) u_in_dly (
                .clk   (clk),
                .reset (reset),
                .en    (in_valid),
                .d     (in_data[NB*k +: NB]),
                .q     (dl[k])
            );
        end

        if (k == LANES - 1) begin : g_out_direct
            assign xpose_data[NB*k +: NB] = sw[k];
        end else begin : g_out_dly
            commutator_p_dly #(.NB(NB), .DEPTH((LANES - 1 - k) * STAGE)) u_out_dly (
                .clk   (clk),
                .reset (reset),
                .en    (in_valid),
                .d     (sw[k]),
                .q     (xpose_data[NB*k +: NB])
            );
        end
    end

    assign out_data = bypass ? in_data : xpose_data;

endmodule

// File: tb/tb_commutator_p.sv
// Directed bench for commutator_p: three configurations (2x1, 2x2, 4x1) checked
// against hand-computed transpose vectors, stalls, restart, bypass and mid-frame reset.

module tb_commutator_p;

    localparam int NB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic            a_start, a_bypass, a_in_valid, a_ov, a_done;
    logic [2*NB-1:0] a_in, a_out;
    logic            b_start, b_bypass, b_in_valid, b_ov, b_done;
    logic [2*NB-1:0] b_in, b_out;
    logic            c_start, c_bypass, c_in_valid, c_ov, c_done;
    logic [4*NB-1:0] c_in, c_out;

    commutator_p #(.NB(NB), .LANES(2), .STAGE(1)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .bypass(a_bypass), .in_valid(a_in_valid),
        .in_data(a_in), .out_valid(a_ov), .out_data(a_out), .done(a_done)
    );
    commutator_p #(.NB(NB), .LANES(2), .STAGE(2)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .bypass(b_bypass), .in_valid(b_in_valid),
        .in_data(b_in), .out_valid(b_ov), .out_data(b_out), .done(b_done)
    );
    commutator_p #(.NB(NB), .LANES(4), .STAGE(1)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .bypass(c_bypass), .in_valid(c_in_valid),
        .in_data(c_in), .out_valid(c_ov), .out_data(c_out), .done(c_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*NB-1:0] p2(input int l0, input int l1);
        return {NB'(l1), NB'(l0)};
    endfunction

    function automatic logic [4*NB-1:0] p4(input int l0, input int l1, input int l2, input int l3);
        return {NB'(l3), NB'(l2), NB'(l1), NB'(l0)};
    endfunction

    function automatic logic [4*NB-1:0] c_vec(input int t);
        return p4(10*t, 10*t + 1, 10*t + 2, 10*t + 3);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*NB-1:0] exp2;
        logic [4*NB-1:0] exp4;
        logic            vpat;

        reset = 1'b1;
        a_start = 0; a_bypass = 0; a_in_valid = 0; a_in = '0;
        b_start = 0; b_bypass = 0; b_in_valid = 0; b_in = '0;
        c_start = 0; c_bypass = 0; c_in_valid = 0; c_in = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #3;
        check("rst_a_ov", 64'(a_ov), 64'(0));
        check("rst_a_done", 64'(a_done), 64'(0));
        check("rst_a_lane0", 64'(a_out[NB-1:0]), 64'(0));
        check("rst_c_lanes012", 64'(c_out[3*NB-1:0]), 64'(0));
        cyc();

        // 2 lanes, stride 1
        for (int t = 0; t < 6; t++) begin
            a_start = (t == 0); a_in_valid = 1'b1; a_in = p2(t, 100 + t);
            #3;
            check($sformatf("a_ov_t%0d", t), 64'(a_ov), 64'(t >= 1));
            check($sformatf("a_done_t%0d", t), 64'(a_done), 64'(t == 1));
            if (t >= 1 && t <= 4) begin
                case (t)
                    1: exp2 = p2(0, 1);
                    2: exp2 = p2(100, 101);
                    3: exp2 = p2(2, 3);
                    default: exp2 = p2(102, 103);
                endcase
                check($sformatf("a_data_t%0d", t), 64'(a_out), 64'(exp2));
            end
            cyc();
        end
        a_start = 0; a_in_valid = 0;

        // 2 lanes, stride 2: continuous, then with 3-cycle stalls after every beat
        for (int gap = 0; gap <= 3; gap += 3) begin
            for (int t = 0; t < 6; t++) begin
                b_start = (t == 0); b_in_valid = 1'b1; b_in = p2(t, 100 + t);
                #3;
                check($sformatf("b_ov_g%0d_t%0d", gap, t), 64'(b_ov), 64'(t >= 2));
                check($sformatf("b_done_g%0d_t%0d", gap, t), 64'(b_done), 64'(t == 2));
                if (t >= 2) begin
                    case (t)
                        2: exp2 = p2(0, 2);
                        3: exp2 = p2(1, 3);
                        4: exp2 = p2(100, 102);
                        default: exp2 = p2(101, 103);
                    endcase
                    check($sformatf("b_data_g%0d_t%0d", gap, t), 64'(b_out), 64'(exp2));
                end
                cyc();
                for (int g = 0; g < gap; g++) begin
                    b_start = 0; b_in_valid = 1'b0; b_in = p2(999, 999);
                    #3;
                    check($sformatf("b_stall_ov_t%0d", t), 64'(b_ov), 64'(0));
                    check($sformatf("b_stall_done_t%0d", t), 64'(b_done), 64'(0));
                    cyc();
                end
            end
            b_start = 0; b_in_valid = 0;
            cyc();
        end

        // 4 lanes, stride 1
        for (int t = 0; t < 8; t++) begin
            c_start = (t == 0); c_in_valid = 1'b1; c_in = c_vec(t);
            #3;
            check($sformatf("c_ov_t%0d", t), 64'(c_ov), 64'(t >= 3));
            check($sformatf("c_done_t%0d", t), 64'(c_done), 64'(t == 3));
            if (t >= 3) begin
                case (t)
                    3: exp4 = p4(0, 10, 20, 30);
                    4: exp4 = p4(1, 11, 21, 31);
                    5: exp4 = p4(2, 12, 22, 32);
                    6: exp4 = p4(3, 13, 23, 33);
                    default: exp4 = p4(40, 50, 60, 70);
                endcase
                check($sformatf("c_data_t%0d", t), 64'(c_out), 64'(exp4));
            end
            cyc();
        end

        // 4 lanes, restart at beat 5 together with in_valid
        for (int t = 0; t < 10; t++) begin
            c_start = (t == 0 || t == 5); c_in_valid = 1'b1; c_in = c_vec(t);
            #3;
            check($sformatf("c_rs_ov_t%0d", t), 64'(c_ov), 64'((t >= 3 && t <= 4) || t >= 8));
            check($sformatf("c_rs_done_t%0d", t), 64'(c_done), 64'(t == 3 || t == 8));
            if (t >= 8) begin
                exp4 = (t == 8) ? p4(50, 60, 70, 80) : p4(51, 61, 71, 81);
                check($sformatf("c_rs_data_t%0d", t), 64'(c_out), 64'(exp4));
            end
            cyc();
        end
        c_start = 0; c_in_valid = 0;

        // bypass on the 2x1 instance
        for (int i = 0; i < 10; i++) begin
            vpat = ((i % 3) != 1);
            a_start = (i == 0); a_bypass = 1'b1; a_in_valid = vpat; a_in = 2*NB'($urandom);
            #3;
            check($sformatf("byp_ov_%0d", i), 64'(a_ov), 64'(vpat));
            check($sformatf("byp_data_%0d", i), 64'(a_out), 64'(a_in));
            check($sformatf("byp_done_%0d", i), 64'(a_done), 64'(0));
            cyc();
        end
        a_start = 1'b1; a_bypass = 1'b0; a_in_valid = 1'b0;
        cyc();
        a_start = 1'b0;

        // mid-frame reset on the 4x1 instance
        for (int t = 0; t < 5; t++) begin
            c_start = (t == 0); c_in_valid = 1'b1; c_in = c_vec(t);
            cyc();
        end
        c_start = 0; reset = 1'b1; c_in = c_vec(9);
        #3;
        check("rst_mid_ov", 64'(c_ov), 64'(0));
        check("rst_mid_done", 64'(c_done), 64'(0));
        cyc();
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            c_in_valid = 1'b1; c_in = c_vec(t);
            #3;
            check($sformatf("post_rst_ov_t%0d", t), 64'(c_ov), 64'(t >= 3));
            check($sformatf("post_rst_done_t%0d", t), 64'(c_done), 64'(t == 3));
            if (t == 3) check("post_rst_data_t3", 64'(c_out), 64'(p4(0, 10, 20, 30)));
            cyc();
        end
        c_in_valid = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
